dpi_stream_sequencer: RTL and testbench

Front-end driver for the bank of per-regex matcher wrappers in the packet-inspection core. Accepts a byte-wide packet stream tagged with a flow key. Maps each key to a 6-bit stream id through a 64-entry flow table, then drives the matcher-side protocol in order: load_state, chars, drain, eop. Collects the per-regex fired vector and emits one result per packet.

---
 rtl/dpi_pkg.sv | 21 ++
 rtl/dpi_flow_table.sv | 92 +++++++++
 rtl/dpi_stream_sequencer.sv | 170 +++++++++++++++++
 tb/tb_dpi_stream_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpi_pkg.sv
// Shared definitions for the packet-inspection front end and the matcher wrappers.
// Holds the sequencer state encoding and the matcher-protocol timing defaults.
package dpi_pkg;

  localparam int STREAM_ID_W      = 6;
  localparam int N_STREAMS        = 64;
  localparam int DEF_LOAD_GAP     = 2;
  localparam int DEF_DRAIN_CYCLES = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_LOAD,
    S_LOAD_WAIT,
    S_STREAM,
    S_DRAIN,
    S_EOP,
    S_REPORT
  } seq_state_t;

endpackage

// File: rtl/dpi_flow_table.sv
// Flow-key CAM with valid bits, lowest-free / round-robin allocation and an enable-row RAM.
// A lookup request returns {hit, idx, new} and the enable row one cycle later.
module dpi_flow_table
  import dpi_pkg::*;
#(
  parameter int                 N_REGEX     = 8,
  parameter int                 KEY_W       = 32,
  parameter logic [N_REGEX-1:0] DEF_EN_MASK = {N_REGEX{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lkp_req,
  input  logic [KEY_W-1:0]       lkp_key,
  output logic                   res_hit,
  output logic [STREAM_ID_W-1:0] res_idx,
  output logic                   res_new,
  output logic [N_REGEX-1:0]     res_en,
  output logic                   alloc,
  output logic                   evict,
  input  logic                   cfg_we,
  input  logic [STREAM_ID_W-1:0] cfg_addr,
  input  logic [N_REGEX-1:0]     cfg_wdata
);

  logic [KEY_W-1:0]       key_mem [N_STREAMS];
  logic [N_REGEX-1:0]     en_mem  [N_STREAMS];
  logic [N_STREAMS-1:0]   valid_reg;
  logic [STREAM_ID_W-1:0] rr_ptr_reg;
  logic [N_STREAMS-1:0]   hit_vec;
  logic                   any_hit;
  logic                   full;
  logic [STREAM_ID_W-1:0] hit_idx;
  logic [STREAM_ID_W-1:0] free_idx;
  logic [STREAM_ID_W-1:0] alloc_idx;
  logic [N_REGEX-1:0]     alloc_row;

  genvar gi;
  generate
    for (gi = 0; gi < N_STREAMS; gi++) begin : g_cmp
      assign hit_vec[gi] = valid_reg[gi] && (key_mem[gi] == lkp_key);
    end
  endgenerate

  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = N_STREAMS - 1; i >= 0; i--) begin
      if (hit_vec[i])    hit_idx  = STREAM_ID_W'(i);
      if (!valid_reg[i]) free_idx = STREAM_ID_W'(i);
    end
  end

  assign any_hit   = |hit_vec;
  assign full      = &valid_reg;
  assign alloc_idx = full ? rr_ptr_reg : free_idx;
  assign alloc     = lkp_req && !any_hit;
  assign evict     = alloc && full;
  // A same-cycle cfg write to the entry being allocated overrides the default row.
  assign alloc_row = (cfg_we && (cfg_addr == alloc_idx)) ? cfg_wdata : DEF_EN_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg  <= '0;
      rr_ptr_reg <= '0;
      res_hit    <= 1'b0;
      res_idx    <= '0;
      res_new    <= 1'b0;
      res_en     <= '0;
    end else if (lkp_req) begin
      res_hit <= any_hit;
      res_new <= !any_hit;
      if (any_hit) begin
        res_idx <= hit_idx;
        res_en  <= en_mem[hit_idx];
      end else begin
        res_idx              <= alloc_idx;
        res_en               <= alloc_row;
        valid_reg[alloc_idx] <= 1'b1;
        if (full) rr_ptr_reg <= rr_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      key_mem[alloc_idx] <= lkp_key;
      en_mem[alloc_idx]  <= DEF_EN_MASK;
    end
    if (cfg_we) en_mem[cfg_addr] <= cfg_wdata;
  end

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Drives the matcher bank per packet: flow lookup, load_state, chars, drain, eop, result.
// Define DPI_SEQ_STATS_EN to add the stat_pkt/stat_new_flow/stat_evict/stat_drop counters.
module dpi_stream_sequencer
  import dpi_pkg::*;
#(
  parameter int                 N_REGEX      = 8,
  parameter int                 KEY_W        = 32,
  parameter int                 LOAD_GAP     = DEF_LOAD_GAP,
  parameter int                 DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter logic [N_REGEX-1:0] DEF_EN_MASK  = {N_REGEX{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             pkt_data,
  input  logic                   pkt_vld,
  input  logic                   pkt_sop,
  input  logic                   pkt_eop,
  input  logic [KEY_W-1:0]       pkt_key,
  output logic                   pkt_rdy,
  input  logic                   cfg_we,
  input  logic [STREAM_ID_W-1:0] cfg_addr,
  input  logic [N_REGEX-1:0]     cfg_wdata,
  output logic                   load_state,
  output logic [STREAM_ID_W-1:0] stream_id,
  output logic                   new_stream_id,
  output logic [7:0]             char_out,
  output logic                   char_out_vld,
  output logic                   eop,
  output logic [N_REGEX-1:0]     enable,
  input  logic [N_REGEX-1:0]     fired_in,
  output logic                   result_vld,
  output logic [STREAM_ID_W-1:0] result_stream_id,
  output logic [N_REGEX-1:0]     result_mask,
  output logic [15:0]            result_len
`ifdef DPI_SEQ_STATS_EN
  ,
  output logic [31:0]            stat_pkt,
  output logic [31:0]            stat_new_flow,
  output logic [31:0]            stat_evict,
  output logic [31:0]            stat_drop
`endif
);

  // Chars leave one cycle after acceptance, so the state lengths are trimmed/extended
  // by one to give exactly LOAD_GAP / DRAIN_CYCLES idle cycles on the matcher side.
  localparam int WAIT_LEN  = (LOAD_GAP > 1) ? LOAD_GAP - 1 : 0;
  localparam int DRAIN_LEN = DRAIN_CYCLES + 1;

  seq_state_t         state_reg, state_next;
  logic [7:0]         cnt_reg, cnt_next;
  logic [KEY_W-1:0]   key_reg;
  logic [15:0]        len_reg;
  logic [7:0]         char_reg;
  logic               char_vld_reg;
  logic [N_REGEX-1:0] mask_reg;
  logic               lkp_req;
  logic               accept;
  logic               stray;
  logic               res_hit;
  logic               res_new;
  logic               alloc;
  logic               evict;

  dpi_flow_table #(
    .N_REGEX    (N_REGEX),
    .KEY_W      (KEY_W),
    .DEF_EN_MASK(DEF_EN_MASK)
  ) u_flow_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .lkp_req  (lkp_req),
    .lkp_key  (key_reg),
    .res_hit  (res_hit),
    .res_idx  (stream_id),
    .res_new  (res_new),
    .res_en   (enable),
    .alloc    (alloc),
    .evict    (evict),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pkt_rdy    = 1'b0;
    lkp_req    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        pkt_rdy = pkt_vld && !pkt_sop;
        if (pkt_vld && pkt_sop) state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        lkp_req    = 1'b1;
        state_next = S_LOAD;
      end
      S_LOAD: begin
        cnt_next   = '0;
        state_next = (WAIT_LEN > 0) ? S_LOAD_WAIT : S_STREAM;
      end
      S_LOAD_WAIT: begin
        cnt_next = cnt_reg + 8'd1;
        if (int'(cnt_reg) >= WAIT_LEN - 1) state_next = S_STREAM;
      end
      S_STREAM: begin
        pkt_rdy  = 1'b1;
        cnt_next = '0;
        if (pkt_vld && pkt_eop) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_next = cnt_reg + 8'd1;
        if (int'(cnt_reg) >= DRAIN_LEN - 1) state_next = S_EOP;
      end
      S_EOP:    state_next = S_REPORT;
      S_REPORT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign accept           = pkt_vld && pkt_rdy && (state_reg == S_STREAM);
  assign stray            = pkt_vld && !pkt_sop && (state_reg == S_IDLE);
  assign load_state       = (state_reg == S_LOAD);
  assign new_stream_id    = load_state && res_new && !res_hit;
  assign eop              = (state_reg == S_EOP);
  assign result_vld       = (state_reg == S_REPORT);
  assign char_out         = char_reg;
  assign char_out_vld     = char_vld_reg;
  assign result_stream_id = stream_id;
  assign result_mask      = mask_reg;
  assign result_len       = len_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      key_reg      <= '0;
      len_reg      <= '0;
      char_reg     <= '0;
      char_vld_reg <= 1'b0;
      mask_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      char_vld_reg <= accept;
      char_reg     <= accept ? pkt_data : 8'h00;
      if ((state_reg == S_IDLE) && pkt_vld && pkt_sop) key_reg <= pkt_key;
      if (load_state) len_reg <= '0;
      else if (accept && (len_reg != 16'hFFFF)) len_reg <= len_reg + 16'd1;
      if (eop) mask_reg <= fired_in & enable;
    end
  end

`ifdef DPI_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkt      <= '0;
      stat_new_flow <= '0;
      stat_evict    <= '0;
      stat_drop     <= '0;
    end else begin
      if (result_vld) stat_pkt      <= stat_pkt + 32'd1;
      if (alloc)      stat_new_flow <= stat_new_flow + 32'd1;
      if (evict)      stat_evict    <= stat_evict + 32'd1;
      if (stray)      stat_drop     <= stat_drop + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer: vector table of packets plus hand-written
// sequences for cfg timing, stray bytes, mid-packet reset and table eviction.
module tb_dpi_stream_sequencer;

  localparam int N_REGEX = 8;
  localparam int KEY_W   = 32;
  localparam int TURN    = 5 + 2 + 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [7:0]         pkt_data = '0;
  logic               pkt_vld = 1'b0;
  logic               pkt_sop = 1'b0;
  logic               pkt_eop = 1'b0;
  logic [KEY_W-1:0]   pkt_key = '0;
  logic               pkt_rdy;
  logic               cfg_we = 1'b0;
  logic [5:0]         cfg_addr = '0;
  logic [N_REGEX-1:0] cfg_wdata = '0;
  logic               load_state;
  logic [5:0]         stream_id;
  logic               new_stream_id;
  logic [7:0]         char_out;
  logic               char_out_vld;
  logic               eop;
  logic [N_REGEX-1:0] enable;
  logic [N_REGEX-1:0] fired_in = '0;
  logic               result_vld;
  logic [5:0]         result_stream_id;
  logic [N_REGEX-1:0] result_mask;
  logic [15:0]        result_len;
`ifdef DPI_SEQ_STATS_EN
  logic [31:0] stat_pkt, stat_new_flow, stat_evict, stat_drop;
`endif

  always #5 clk = ~clk;

  dpi_stream_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_data(pkt_data), .pkt_vld(pkt_vld), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_key(pkt_key), .pkt_rdy(pkt_rdy),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .load_state(load_state), .stream_id(stream_id), .new_stream_id(new_stream_id),
    .char_out(char_out), .char_out_vld(char_out_vld), .eop(eop), .enable(enable),
    .fired_in(fired_in), .result_vld(result_vld), .result_stream_id(result_stream_id),
    .result_mask(result_mask), .result_len(result_len)
`ifdef DPI_SEQ_STATS_EN
    , .stat_pkt(stat_pkt), .stat_new_flow(stat_new_flow),
    .stat_evict(stat_evict), .stat_drop(stat_drop)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  sid;
    logic [5:0]  rsid;
    logic        nw;
    logic [15:0] len;
    logic [7:0]  mask;
    int          gap_load;
    int          gap_drain;
    int          nchars;
    int          span;
    int          turn;
    bit          data_ok;
    bit          timeout;
  } pkt_res_t;

  typedef struct {
    logic [31:0] key;
    int          nb;
    logic [7:0]  fired;
    logic [5:0]  sid;
    logic        nw;
    logic [7:0]  mask;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sends one packet and observes the matcher side until the result pulse.
  task automatic run_pkt(input logic [31:0] key, input int nb, input logic [7:0] fired,
                         input int cfg_at, input logic [5:0] ca, input logic [7:0] cd,
                         output pkt_res_t r);
    int cyc = 0, sent = 0, load_c = -1, first_c = -1, last_c = -1, eop_c = -1;
    bit done = 0, acc;
    r = '{default: 0};
    r.data_ok = 1;
    @(posedge clk); #1;
    pkt_vld = 1; pkt_sop = 1; pkt_eop = (nb == 1); pkt_key = key; pkt_data = 8'h40;
    fired_in = fired;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (load_state) begin load_c = cyc; r.sid = stream_id; r.nw = new_stream_id; end
      if (char_out_vld) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        if (char_out != 8'(64 + r.nchars)) r.data_ok = 0;
        r.nchars++;
      end
      if (eop) eop_c = cyc;
      if (result_vld) begin
        r.len = result_len; r.mask = result_mask; r.rsid = result_stream_id;
        r.turn = cyc; done = 1;
      end
      acc = pkt_vld && pkt_rdy;
      @(posedge clk); #1;
      cfg_we = (cyc == cfg_at); cfg_addr = ca; cfg_wdata = cd;
      if (acc) begin
        sent++;
        if (sent < nb) begin
          pkt_sop = 0; pkt_data = 8'(64 + sent); pkt_eop = (sent == nb - 1);
        end else begin
          pkt_vld = 0; pkt_sop = 0; pkt_eop = 0;
        end
      end
    end
    fired_in = '0; cfg_we = 0; pkt_vld = 0; pkt_sop = 0; pkt_eop = 0;
    r.timeout   = !done;
    r.gap_load  = first_c - load_c - 1;
    r.gap_drain = eop_c - last_c - 1;
    r.span      = last_c - first_c + 1;
  endtask

  task automatic check_pkt(input string tag, input pkt_res_t r, input int nb,
                           input logic [5:0] sid, input logic nw, input logic [7:0] mask);
    $display("pkt %s: bytes=%0d sid=%0d new=%0b len=%0d mask=0x%02h cycles=%0d",
             tag, nb, r.sid, r.nw, r.len, r.mask, r.turn);
    check({tag, "_timeout"}, 64'(r.timeout), 0);
    check({tag, "_stream_id"}, 64'(r.sid), 64'(sid));
    check({tag, "_result_stream_id"}, 64'(r.rsid), 64'(sid));
    check({tag, "_new"}, 64'(r.nw), 64'(nw));
    check({tag, "_len"}, 64'(r.len), 64'(nb));
    check({tag, "_mask"}, 64'(r.mask), 64'(mask));
    check({tag, "_load_gap"}, 64'(r.gap_load), 2);
    check({tag, "_drain_gap"}, 64'(r.gap_drain), 3);
    check({tag, "_nchars"}, 64'(r.nchars), 64'(nb));
    check({tag, "_char_span"}, 64'(r.span), 64'(nb));
    check({tag, "_char_data"}, 64'(r.data_ok), 1);
    check({tag, "_turnaround"}, 64'(r.turn), 64'(TURN + nb));
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 0;
    $display("cfg write addr=%0d data=0x%02h", a, d);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({pkt_rdy, load_state, stream_id, new_stream_id, char_out, char_out_vld, eop,
                enable, result_vld, result_stream_id, result_mask, result_len});
  endfunction

  initial begin
    vec_t     vecs [5];
    pkt_res_t r;
    bit       ok;
    int       bad;

    vecs[0] = '{32'hA, 4, 8'h00, 6'd0, 1'b1, 8'h00};
    vecs[1] = '{32'hA, 3, 8'hFF, 6'd0, 1'b0, 8'hFF};
    vecs[2] = '{32'hB, 2, 8'h3C, 6'd1, 1'b1, 8'h3C};
    vecs[3] = '{32'hC, 1, 8'hA5, 6'd2, 1'b1, 8'hA5};
    vecs[4] = '{32'hB, 5, 8'h81, 6'd1, 1'b0, 8'h81};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 0);
    rst_n = 1;

    for (int i = 0; i < 5; i++) begin
      run_pkt(vecs[i].key, vecs[i].nb, vecs[i].fired, -1, 6'd0, 8'h00, r);
      check_pkt($sformatf("vec%0d", i), r, vecs[i].nb, vecs[i].sid, vecs[i].nw, vecs[i].mask);
    end

    // Enable-row programming: idle write, mid-packet write, collision with allocation.
    cfg_write(6'd1, 8'h05);
    run_pkt(32'hB, 3, 8'hFF, 5, 6'd1, 8'h0F, r);
    check_pkt("cfg_idle", r, 3, 6'd1, 1'b0, 8'h05);
    run_pkt(32'hB, 2, 8'hFF, -1, 6'd0, 8'h00, r);
    check_pkt("cfg_midpkt_next", r, 2, 6'd1, 1'b0, 8'h0F);
    run_pkt(32'hD, 2, 8'hFF, 1, 6'd3, 8'h11, r);
    check_pkt("cfg_alloc_collide", r, 2, 6'd3, 1'b1, 8'h11);

    // Stray bytes in IDLE are consumed and dropped.
    @(posedge clk); #1;
    pkt_vld = 1; pkt_sop = 0; pkt_data = 8'h77;
    ok = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (pkt_rdy !== 1'b1) ok = 0;
      @(posedge clk); #1;
    end
    pkt_vld = 0;
    check("stray_rdy", 64'(ok), 1);
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (char_out_vld !== 1'b0 || load_state !== 1'b0) ok = 0;
    end
    check("stray_no_char", 64'(ok), 1);
    $display("stray bytes: 3 sent");
`ifdef DPI_SEQ_STATS_EN
    check("stat_drop", 64'(stat_drop), 3);
`endif
    run_pkt(32'hE, 1, 8'h0F, -1, 6'd0, 8'h00, r);
    check_pkt("one_byte", r, 1, 6'd4, 1'b1, 8'h0F);

    // Reset while streaming: outputs clear at once and no eop follows.
    @(posedge clk); #1;
    pkt_vld = 1; pkt_sop = 1; pkt_key = 32'hB; pkt_data = 8'h40; pkt_eop = 0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (char_out_vld) ok = 1;
      else begin @(posedge clk); #1; pkt_sop = 0; end
    end
    check("abort_reach_stream", 64'(ok), 1);
    rst_n = 0; pkt_vld = 0; pkt_sop = 0;
    #1;
    check("abort_outputs_zero", all_outs(), 0);
    ok = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1;
      if (eop !== 1'b0 || result_vld !== 1'b0) ok = 0;
    end
    check("abort_no_eop", 64'(ok), 1);
    $display("mid-stream reset applied");
    run_pkt(32'hB, 2, 8'hFF, -1, 6'd0, 8'h00, r);
    check_pkt("after_reset", r, 2, 6'd0, 1'b1, 8'hFF);

    // Fill the table from empty, then evict round-robin.
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      run_pkt(32'h1000 + i, 1, 8'h00, -1, 6'd0, 8'h00, r);
      $display("fill key=0x%0h sid=%0d new=%0b", 32'h1000 + i, r.sid, r.nw);
      if (r.timeout || r.sid != 6'(i) || r.nw != 1'b1) bad++;
    end
    check("fill_sid_new", 64'(bad), 0);
    run_pkt(32'h1040, 1, 8'h00, -1, 6'd0, 8'h00, r);
    check_pkt("evict65", r, 1, 6'd0, 1'b1, 8'h00);
    run_pkt(32'h1041, 1, 8'h00, -1, 6'd0, 8'h00, r);
    check_pkt("evict66", r, 1, 6'd1, 1'b1, 8'h00);
`ifdef DPI_SEQ_STATS_EN
    check("stat_evict", 64'(stat_evict), 2);
    check("stat_new_flow", 64'(stat_new_flow), 66);
`endif
    run_pkt(32'h1002, 1, 8'h00, -1, 6'd0, 8'h00, r);
    check_pkt("hit_after_evict", r, 1, 6'd2, 1'b0, 8'h00);
    run_pkt(32'h1000, 1, 8'h00, -1, 6'd0, 8'h00, r);
    check_pkt("evicted_key_realloc", r, 1, 6'd2, 1'b1, 8'h00);
    run_pkt(32'h1040, 1, 8'h00, -1, 6'd0, 8'h00, r);
    check_pkt("evictor_hit", r, 1, 6'd0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
